// File: rtl/dds_freq_meter_if.sv
// Sample-stream and result bundle for dds_freq_meter.
// The DUT uses the slave modport; the source and result consumer use the master modport.
interface dds_freq_meter_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic [31:0]       k_est;
    logic              k_valid;
    logic              ovf;
    logic              busy;

    modport master (
        output din, din_valid,
        input  k_est, k_valid, ovf, busy
    );

    modport slave (
        input  din, din_valid,
        output k_est, k_valid, ovf, busy
    );
endinterface

// File: rtl/dds_freq_meter.sv
// Recovers the DDS phase-increment word from a sampled tone: the period is timed over NPER
// rising mid-scale crossings, then K = 2^(32+NPER_LOG2) / T by restoring division.
// Optional macro FREQ_METER_IIR_EN adds first-order IIR smoothing of k_est.
module dds_freq_meter #(
    parameter int DATA_W    = 10,
    parameter int MID       = 512,
    parameter int HYST      = 8,
    parameter int NPER_LOG2 = 2,
    parameter int CNT_W     = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    dds_freq_meter_if.slave bus
);
    localparam int NPER = 1 << NPER_LOG2;
    localparam int QW   = 33 + NPER_LOG2;
    localparam int SW   = $clog2(QW + 1);
    localparam int XW   = NPER_LOG2 + 1;

    localparam logic [DATA_W-1:0] THR_LO    = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] THR_HI    = DATA_W'(MID + HYST);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [XW-1:0]     XING_LAST = XW'(NPER - 1);
    localparam logic [SW-1:0]     STEP_LAST = SW'(QW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIV     = 2'd2
    } state_t;

    // A quotient wider than 32 bits saturates to the largest representable K.
    function automatic logic [31:0] sat_quot(input logic [QW-1:0] q);
        logic [31:0] res;
        if (|q[QW-1:32]) begin
            res = 32'hFFFF_FFFF;
        end else begin
            res = q[31:0];
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              low_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XW-1:0]     xing_r;
    logic [CNT_W-1:0]  t_r;
    logic [CNT_W-1:0]  rem_r;
    logic [QW-1:0]     q_r;
    logic [SW-1:0]     step_r;
    logic [31:0]       k_est_r;
    logic              k_valid_r;
    logic              ovf_r;
    logic              busy_r;

    logic              is_low_s;
    logic              is_high_s;
    logic              cross_s;
    logic              done_meas_s;
    logic              timeout_s;
    logic              div_last_s;
    logic              num_bit_s;
    logic              ge_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [CNT_W:0]    rem_sh_s;
    logic [CNT_W-1:0]  rem_diff_s;
    logic [CNT_W-1:0]  rem_nxt_s;
    logic [31:0]       q_sat_s;

`ifdef FREQ_METER_IIR_EN
    logic              primed_r;
    logic signed [32:0] iir_diff_s;
    logic [31:0]       iir_next_s;

    // Filter update: k + (q - k)/4 with an arithmetic shift on the signed difference.
    always_comb begin
        iir_diff_s = $signed({1'b0, q_sat_s}) - $signed({1'b0, k_est_r});
        iir_next_s = 32'($signed({1'b0, k_est_r}) + (iir_diff_s >>> 2));
    end
`endif

    // Crossing detection, measurement terminations and one restoring-division step.
    always_comb begin
        is_low_s    = (bus.din < THR_LO);
        is_high_s   = (bus.din >= THR_HI);
        cross_s     = bus.din_valid & low_r & is_high_s;
        cnt_inc_s   = cnt_r + CNT_W'(1);
        done_meas_s = (state_r == MEASURE) && cross_s && (xing_r == XING_LAST);
        timeout_s   = (state_r == MEASURE) && bus.din_valid && !done_meas_s
                      && (cnt_inc_s == CNT_MAX);
        div_last_s  = (state_r == DIV) && (step_r == STEP_LAST);
        // The numerator is a single one at its MSB, so only the first step shifts in a 1.
        num_bit_s   = (step_r == {SW{1'b0}});
        rem_sh_s    = {rem_r, num_bit_s};
        rem_diff_s  = rem_sh_s[CNT_W-1:0] - t_r;
        ge_s        = (rem_sh_s >= {1'b0, t_r});
        if (ge_s) begin
            rem_nxt_s = rem_diff_s;
        end else begin
            rem_nxt_s = rem_sh_s[CNT_W-1:0];
        end
        q_sat_s     = sat_quot(q_r);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cross_s) begin
                    state_nxt_s = MEASURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEASURE: begin
                if (done_meas_s) begin
                    state_nxt_s = DIV;
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MEASURE;
                end
            end
            DIV: begin
                if (div_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Low flag tracks valid samples in every state, including during division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_r <= 1'b0;
        end else if (bus.din_valid) begin
            if (is_low_s) begin
                low_r <= 1'b1;
            end else if (cross_s) begin
                low_r <= 1'b0;
            end
        end
    end

    // Sample counter, crossing count, latched period and divider datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            xing_r <= {XW{1'b0}};
            t_r    <= {CNT_W{1'b0}};
            rem_r  <= {CNT_W{1'b0}};
            q_r    <= {QW{1'b0}};
            step_r <= {SW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    xing_r <= {XW{1'b0}};
                end
                MEASURE: begin
                    if (bus.din_valid) begin
                        cnt_r <= cnt_inc_s;
                    end
                    if (cross_s) begin
                        xing_r <= xing_r + XW'(1);
                    end
                    if (done_meas_s) begin
                        t_r    <= cnt_inc_s;
                        rem_r  <= {CNT_W{1'b0}};
                        q_r    <= {QW{1'b0}};
                        step_r <= {SW{1'b0}};
                    end
                end
                DIV: begin
                    if (!div_last_s) begin
                        rem_r  <= rem_nxt_s;
                        q_r    <= {q_r[QW-2:0], ge_s};
                        step_r <= step_r + SW'(1);
                    end
                end
                default: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    xing_r <= {XW{1'b0}};
                end
            endcase
        end
    end

    // Result and strobe registers; k_est only moves alongside a k_valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_est_r   <= 32'h0;
            k_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
`ifdef FREQ_METER_IIR_EN
            primed_r  <= 1'b0;
`endif
        end else begin
            k_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
            busy_r    <= (state_nxt_s != IDLE);
            if (timeout_s) begin
                k_valid_r <= 1'b1;
                ovf_r     <= 1'b1;
`ifdef FREQ_METER_IIR_EN
                k_est_r   <= k_est_r;
`else
                k_est_r   <= 32'h0;
`endif
            end else if (div_last_s) begin
                k_valid_r <= 1'b1;
`ifdef FREQ_METER_IIR_EN
                if (primed_r) begin
                    k_est_r <= iir_next_s;
                end else begin
                    k_est_r  <= q_sat_s;
                    primed_r <= 1'b1;
                end
`else
                k_est_r   <= q_sat_s;
`endif
            end
        end
    end

    assign bus.k_est   = k_est_r;
    assign bus.k_valid = k_valid_r;
    assign bus.ovf     = ovf_r;
    assign bus.busy    = busy_r;
endmodule
